// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback slice: opcodes, default
// widths and opcode classification helpers.
package alu_pkg;

  localparam int DEF_DW   = 8;
  localparam int DEF_NREG = 8;
  localparam int DEF_AW   = 3;
  localparam int DEF_CNTW = 16;
  localparam int CW       = 4;

  typedef logic [CW-1:0] opcode_t;

  localparam opcode_t OP_ADD  = 4'h0;
  localparam opcode_t OP_SUB  = 4'h1;
  localparam opcode_t OP_AND  = 4'h2;
  localparam opcode_t OP_OR   = 4'h3;
  localparam opcode_t OP_XOR  = 4'h4;
  localparam opcode_t OP_NOT  = 4'h5;
  localparam opcode_t OP_SHL  = 4'h6;
  localparam opcode_t OP_SHR  = 4'h7;
  localparam opcode_t OP_INC  = 4'h8;
  localparam opcode_t OP_DEC  = 4'h9;
  localparam opcode_t OP_PASS = 4'hA;
  localparam opcode_t OP_LT   = 4'hB;
  localparam opcode_t OP_EQ   = 4'hC;
  localparam opcode_t OP_NOP0 = 4'hD;
  localparam opcode_t OP_NOP1 = 4'hE;
  localparam opcode_t OP_NOP2 = 4'hF;

  // Every opcode up to and including OP_EQ produces a register result.
  function automatic logic writes_rd(input opcode_t op);
    return (op <= OP_EQ);
  endfunction

  // Only add and subtract update the sticky carry flag.
  function automatic logic sets_carry(input opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREG x DW register file: three combinational read ports, a writeback port
// and a host load port. When both write the same register on one edge the
// load port wins.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int NREG = DEF_NREG,
  parameter int AW   = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data,
  input  logic [AW-1:0] rc_addr,
  output logic [DW-1:0] rc_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data
);

  logic [DW-1:0] regs_reg [NREG];

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      // One register per entry; load port has priority over writeback.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          regs_reg[gi] <= '0;
        end else if (ld_en && (ld_addr == AW'(gi))) begin
          regs_reg[gi] <= ld_data;
        end else if (wr_en && (wr_addr == AW'(gi))) begin
          regs_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

  assign ra_data = regs_reg[ra_addr];
  assign rb_data = regs_reg[rb_addr];
  assign rc_data = regs_reg[rc_addr];

endmodule

// File: rtl/alu_issue_wb.sv
// Operand-issue / writeback stage around an external combinational ALU.
// Accepted instructions read operands (bypassed from the retiring op) into
// the EX register that drives the ALU; the following edge retires the op,
// writes its result back and updates the carry flag and retire counter.
module alu_issue_wb
  import alu_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int NREG = DEF_NREG,
  parameter int AW   = DEF_AW,
  parameter int CNTW = DEF_CNTW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_ctrl,
  input  logic [AW-1:0]   in_rd,
  input  logic [AW-1:0]   in_rs,
  input  logic [AW-1:0]   in_rt,
  input  logic            ld_en,
  input  logic [AW-1:0]   ld_addr,
  input  logic [DW-1:0]   ld_data,
  output logic [3:0]      alu_ctrl,
  output logic [DW-1:0]   alu_x,
  output logic [DW-1:0]   alu_y,
  input  logic [DW-1:0]   alu_out,
  input  logic            alu_carry,
  output logic            wb_valid,
  output logic [AW-1:0]   wb_addr,
  output logic [DW-1:0]   wb_data,
  output logic            flag_c,
  output logic [CNTW-1:0] retired,
  input  logic [AW-1:0]   dbg_addr,
  output logic [DW-1:0]   dbg_data
);

  logic            ex_valid_reg;
  opcode_t         ctrl_reg;
  logic [AW-1:0]   ex_rd_reg;
  logic [DW-1:0]   x_reg;
  logic [DW-1:0]   y_reg;
  logic            wb_valid_reg;
  logic [AW-1:0]   wb_addr_reg;
  logic [DW-1:0]   wb_data_reg;
  logic            flag_c_reg;
  logic [CNTW-1:0] retired_reg;

  logic            fire;
  logic            ex_wr;
  logic [DW-1:0]   rs_data;
  logic [DW-1:0]   rt_data;
  logic [DW-1:0]   x_next;
  logic [DW-1:0]   y_next;

  // Host loads take the register file write path, so they block issue.
  assign in_ready = !ld_en;
  assign fire     = in_valid && in_ready;

  // The op sitting in EX retires on the coming edge; if it writes, its
  // result is the freshest value for that register.
  assign ex_wr = ex_valid_reg && writes_rd(ctrl_reg);

  alu_regfile #(
    .DW   (DW),
    .NREG (NREG),
    .AW   (AW)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (in_rs),
    .ra_data (rs_data),
    .rb_addr (in_rt),
    .rb_data (rt_data),
    .rc_addr (dbg_addr),
    .rc_data (dbg_data),
    .wr_en   (ex_wr),
    .wr_addr (ex_rd_reg),
    .wr_data (alu_out),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  // Operand bypass from the retiring op; both sources use the same rule.
  always_comb begin
    x_next = rs_data;
    y_next = rt_data;
    if (ex_wr && (ex_rd_reg == in_rs)) x_next = alu_out;
    if (ex_wr && (ex_rd_reg == in_rt)) y_next = alu_out;
  end

  // EX register: loads on handshake, otherwise operands hold and valid drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_reg <= 1'b0;
      ctrl_reg     <= '0;
      ex_rd_reg    <= '0;
      x_reg        <= '0;
      y_reg        <= '0;
    end else begin
      ex_valid_reg <= fire;
      if (fire) begin
        ctrl_reg  <= in_ctrl;
        ex_rd_reg <= in_rd;
        x_reg     <= x_next;
        y_reg     <= y_next;
      end
    end
  end

  // Writeback report, sticky carry and saturating retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_reg <= 1'b0;
      wb_addr_reg  <= '0;
      wb_data_reg  <= '0;
      flag_c_reg   <= 1'b0;
      retired_reg  <= '0;
    end else begin
      wb_valid_reg <= ex_wr;
      if (ex_wr) begin
        wb_addr_reg <= ex_rd_reg;
        wb_data_reg <= alu_out;
      end
      if (ex_valid_reg && sets_carry(ctrl_reg)) begin
        flag_c_reg <= alu_carry;
      end
      if (ex_valid_reg && (retired_reg != {CNTW{1'b1}})) begin
        retired_reg <= retired_reg + CNTW'(1);
      end
    end
  end

  assign alu_ctrl = ctrl_reg;
  assign alu_x    = x_reg;
  assign alu_y    = y_reg;
  assign wb_valid = wb_valid_reg;
  assign wb_addr  = wb_addr_reg;
  assign wb_data  = wb_data_reg;
  assign flag_c   = flag_c_reg;
  assign retired  = retired_reg;

endmodule

// File: tb/tb_alu_issue_wb.sv
// Directed bench for alu_issue_wb with a small behavioural ALU attached.
module tb_alu_issue_wb;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_ctrl;
  logic [2:0]  in_rd;
  logic [2:0]  in_rs;
  logic [2:0]  in_rt;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [7:0]  ld_data;
  logic [3:0]  alu_ctrl;
  logic [7:0]  alu_x;
  logic [7:0]  alu_y;
  logic [7:0]  alu_out;
  logic        alu_carry;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [7:0]  wb_data;
  logic        flag_c;
  logic [15:0] retired;
  logic [2:0]  dbg_addr;
  logic [7:0]  dbg_data;

  int errors = 0;
  int checks = 0;

  alu_issue_wb dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_rd     (in_rd),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .alu_ctrl  (alu_ctrl),
    .alu_x     (alu_x),
    .alu_y     (alu_y),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .flag_c    (flag_c),
    .retired   (retired),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: add, subtract (carry = borrow), and; others pass x.
  always_comb begin
    alu_out   = alu_x;
    alu_carry = 1'b0;
    case (alu_ctrl)
      4'h0: {alu_carry, alu_out} = {1'b0, alu_x} + {1'b0, alu_y};
      4'h1: {alu_carry, alu_out} = {1'b0, alu_x} - {1'b0, alu_y};
      4'h2: alu_out = alu_x & alu_y;
      default: alu_out = alu_x;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  task automatic set_op(input logic [3:0] c, input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt);
    in_valid = 1'b1; in_ctrl = c; in_rd = rd; in_rs = rs; in_rt = rt;
  endtask

  task automatic rd_dbg(input logic [2:0] a, input logic [7:0] exp, input string tag);
    dbg_addr = a;
    #1;
    chk(tag, {24'd0, dbg_data}, {24'd0, exp});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_rd = '0; in_rs = '0; in_rt = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    #3;
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_flag_c",   {31'd0, flag_c}, 32'd0);
    chk("rst_retired",  {16'd0, retired}, 32'd0);
    chk("rst_alu_x",    {24'd0, alu_x}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    ld_en = 1'b1;
    #1;
    chk("rst_in_ready_ld", {31'd0, in_ready}, 32'd0);
    ld_en = 1'b0;
    step(); step();
    rst = 1'b0;
    step();

    // 1. 7F + 01 -> R3 = 80, no carry
    ld_en = 1'b1; ld_addr = 3'd1; ld_data = 8'h7F;
    #1;
    chk("t1_ready_during_ld", {31'd0, in_ready}, 32'd0);
    step(); ld_en = 1'b0;
    load(3'd2, 8'h01);
    set_op(4'h0, 3'd3, 3'd1, 3'd2);
    step(); in_valid = 1'b0;
    chk("t1_alu_x", {24'd0, alu_x}, 32'h7F);
    chk("t1_alu_y", {24'd0, alu_y}, 32'h01);
    chk("t1_wb_valid_early", {31'd0, wb_valid}, 32'd0);
    step();
    chk("t1_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("t1_wb_addr",  {29'd0, wb_addr}, 32'd3);
    chk("t1_wb_data",  {24'd0, wb_data}, 32'h80);
    chk("t1_flag_c",   {31'd0, flag_c}, 32'd0);
    chk("t1_retired",  {16'd0, retired}, 32'd1);
    rd_dbg(3'd3, 8'h80, "t1_dbg_r3");
    step();
    chk("t1_wb_pulse_end", {31'd0, wb_valid}, 32'd0);

    // 2. FF + 01 (carry) then AND back-to-back
    load(3'd1, 8'hFF);
    load(3'd2, 8'h01);
    set_op(4'h0, 3'd4, 3'd1, 3'd2);
    step();
    set_op(4'h2, 3'd5, 3'd1, 3'd2);
    step(); in_valid = 1'b0;
    chk("t2_add_wb_addr", {29'd0, wb_addr}, 32'd4);
    chk("t2_add_wb_data", {24'd0, wb_data}, 32'h00);
    chk("t2_add_flag_c",  {31'd0, flag_c}, 32'd1);
    step();
    chk("t2_and_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("t2_and_wb_addr",  {29'd0, wb_addr}, 32'd5);
    chk("t2_and_wb_data",  {24'd0, wb_data}, 32'h01);
    chk("t2_and_flag_c",   {31'd0, flag_c}, 32'd1);
    chk("t2_retired",      {16'd0, retired}, 32'd3);
    rd_dbg(3'd4, 8'h00, "t2_dbg_r4");

    // 3. Bypass: R3 = 5+3, then R6 = R3 - R1
    load(3'd1, 8'h05);
    load(3'd2, 8'h03);
    set_op(4'h0, 3'd3, 3'd1, 3'd2);
    step();
    set_op(4'h1, 3'd6, 3'd3, 3'd1);
    step(); in_valid = 1'b0;
    chk("t3_add_wb_data", {24'd0, wb_data}, 32'h08);
    chk("t3_bypass_x",    {24'd0, alu_x}, 32'h08);
    chk("t3_sub_y",       {24'd0, alu_y}, 32'h05);
    step();
    chk("t3_sub_wb_addr", {29'd0, wb_addr}, 32'd6);
    chk("t3_sub_wb_data", {24'd0, wb_data}, 32'h03);
    chk("t3_flag_c",      {31'd0, flag_c}, 32'd0);
    chk("t3_retired",     {16'd0, retired}, 32'd5);

    // 4. NOP with rd=1
    set_op(4'hE, 3'd1, 3'd2, 3'd2);
    step(); in_valid = 1'b0;
    step();
    chk("t4_nop_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("t4_retired",      {16'd0, retired}, 32'd6);
    rd_dbg(3'd1, 8'h05, "t4_dbg_r1");

    // 5. Load blocks issue; load and retire collide on R2
    set_op(4'h0, 3'd7, 3'd1, 3'd2);
    ld_en = 1'b1; ld_addr = 3'd0; ld_data = 8'hAA;
    #1;
    chk("t5_in_ready", {31'd0, in_ready}, 32'd0);
    step(); in_valid = 1'b0; ld_en = 1'b0;
    step();
    chk("t5_no_accept_wb", {31'd0, wb_valid}, 32'd0);
    chk("t5_no_accept_ret", {16'd0, retired}, 32'd6);
    rd_dbg(3'd0, 8'hAA, "t5_dbg_r0");
    rd_dbg(3'd7, 8'h00, "t5_dbg_r7");
    set_op(4'h0, 3'd2, 3'd1, 3'd1);
    step(); in_valid = 1'b0;
    ld_en = 1'b1; ld_addr = 3'd2; ld_data = 8'h5A;
    step(); ld_en = 1'b0;
    chk("t5_col_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("t5_col_wb_data",  {24'd0, wb_data}, 32'h0A);
    chk("t5_col_retired",  {16'd0, retired}, 32'd7);
    rd_dbg(3'd2, 8'h5A, "t5_dbg_r2");

    // 6. Set carry, then reset with an op in EX
    set_op(4'h0, 3'd4, 3'd0, 3'd0);
    step(); in_valid = 1'b0;
    step();
    chk("t6_wb_data", {24'd0, wb_data}, 32'h54);
    chk("t6_flag_c",  {31'd0, flag_c}, 32'd1);
    chk("t6_retired", {16'd0, retired}, 32'd8);
    set_op(4'h0, 3'd3, 3'd1, 3'd1);
    step(); in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_flag_c",  {31'd0, flag_c}, 32'd0);
    chk("t6_rst_retired", {16'd0, retired}, 32'd0);
    chk("t6_rst_wb",      {31'd0, wb_valid}, 32'd0);
    step(); step();
    rst = 1'b0;
    step();
    chk("t6_post_wb",      {31'd0, wb_valid}, 32'd0);
    chk("t6_post_retired", {16'd0, retired}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      rd_dbg(3'(i), 8'h00, $sformatf("t6_dbg_r%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
